// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;

  // Default operand/result width.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage : serial_add_pkg

// File: rtl/piso_shift.sv
// Parallel-load, LSB-first shift register. bit_o always shows the current LSB.
// A shift moves the contents right and fills the top with zeros.
module piso_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next contents: a load takes priority over a shift.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = data_i;
    end else if (shift_i) begin
      q_d = {1'b0, q_q[WIDTH-1:1]};
    end
  end

  // Contents register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bit_o = q_q[0];

endmodule : piso_shift

// File: rtl/serial_add_ctrl.sv
// Bit-serial operand sequencer and result collector for an external
// registered full-adder stage (which updates on the falling clock edge).
// Presents one bit pair per cycle LSB-first, loops the adder carry back,
// and assembles the sum bits into a parallel result.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             fa_a_q,   fa_a_d;
  logic             fa_b_q,   fa_b_d;
  logic             fa_cin_q, fa_cin_d;

  logic             load;
  logic             shift;
  logic             a_bit;
  logic             b_bit;

  // Bit 0 goes straight to the adder on the start edge, so the shifters
  // only hold the remaining upper bits.
  piso_shift #(.WIDTH(WIDTH)) u_shift_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .shift_i(shift),
    .data_i ({1'b0, op_a[WIDTH-1:1]}),
    .bit_o  (a_bit)
  );

  piso_shift #(.WIDTH(WIDTH)) u_shift_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .shift_i(shift),
    .data_i ({1'b0, op_b[WIDTH-1:1]}),
    .bit_o  (b_bit)
  );

  // Next-state, sequencing and result collection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    result_d = result_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fa_a_d   = fa_a_q;
    fa_b_d   = fa_b_q;
    fa_cin_d = fa_cin_q;
    load     = 1'b0;
    shift    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          fa_a_d   = op_a[0];
          fa_b_d   = op_b[0];
          fa_cin_d = cin;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shift    = 1'b1;
        sum_d    = {fa_sum, sum_q[WIDTH-1:1]};
        fa_cin_d = fa_cout;
        fa_a_d   = a_bit;
        fa_b_d   = b_bit;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = {fa_sum, sum_q[WIDTH-1:1]};
          cout_d   = fa_cout;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          fa_a_d   = 1'b0;
          fa_b_d   = 1'b0;
          fa_cin_d = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sum_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fa_a_q   <= 1'b0;
      fa_b_q   <= 1'b0;
      fa_cin_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fa_a_q   <= fa_a_d;
      fa_b_q   <= fa_b_d;
      fa_cin_q <= fa_cin_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign fa_a   = fa_a_q;
  assign fa_b   = fa_b_q;
  assign fa_cin = fa_cin_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl wired to a falling-edge registered
// full-adder stage.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       fa_a;
  logic       fa_b;
  logic       fa_cin;
  logic       fa_sum;
  logic       fa_cout;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  logic [7:0]  prev_res;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .fa_a   (fa_a),
    .fa_b   (fa_b),
    .fa_cin (fa_cin),
    .fa_sum (fa_sum),
    .fa_cout(fa_cout)
  );

  // Registered full-adder stage, updates on the falling edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa_sum  <= 1'b0;
      fa_cout <= 1'b0;
    end else begin
      fa_sum  <= fa_a ^ fa_b ^ fa_cin;
      fa_cout <= (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One addition started from IDLE. Must be called 1 time unit after a rising edge.
  // With intrude set, a start with op_a=0x11 is presented for the edge k+3.
  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [7:0] er, input logic ec,
                         input bit intrude);
    logic [7:0] seq_a;
    logic [7:0] seq_b;
    seq_a = '0;
    seq_b = '0;
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    tick();                       // edge k
    start = 1'b0;
    op_a  = 8'hC3;
    op_b  = 8'h3C;
    cin   = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) tick();          // edge k+i
      if (intrude && i == 2) begin
        start = 1'b1;
        op_a  = 8'h11;
      end
      if (intrude && i == 3) start = 1'b0;
      if (i < 8) begin
        seq_a[i] = fa_a;
        seq_b[i] = fa_b;
        check({tag, " busy"}, busy, 1);
        check({tag, " done early"}, done, 0);
        check({tag, " result held"}, result, prev_res);
      end else begin
        check({tag, " done"}, done, 1);
        check({tag, " busy end"}, busy, 0);
        check({tag, " result"}, result, er);
        check({tag, " cout"}, cout, ec);
        check({tag, " fa idle"}, {fa_a, fa_b, fa_cin}, 0);
      end
    end
    check({tag, " fa_a seq"}, seq_a, a);
    check({tag, " fa_b seq"}, seq_b, b);
    tick();
    check({tag, " done pulse"}, done, 0);
    check({tag, " idle"}, busy, 0);
    check({tag, " result keep"}, result, er);
    prev_res = er;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    op_a     = '0;
    op_b     = '0;
    cin      = 1'b0;
    prev_res = 8'h00;

    #3;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);
    check("rst cout", cout, 0);
    check("rst fa", {fa_a, fa_b, fa_cin}, 0);
    #9 rst_n = 1'b1;
    tick();

    run_add("5A+33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b0);
    run_add("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_add("intrude", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);

    // Reset in the middle of 0x0F+0x01.
    op_a  = 8'h0F;
    op_b  = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    tick();                       // edge k
    start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    check("mid busy pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort fa", {fa_a, fa_b, fa_cin}, 0);
    check("abort result", result, 8'h00);
    check("abort cout", cout, 0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    prev_res = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("no done after abort", done, 0);
      check("idle after abort", busy, 0);
    end
    run_add("01+01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Start held high: accepted at k and again at k+9.
    op_a  = 8'h10;
    op_b  = 8'h20;
    cin   = 1'b0;
    start = 1'b1;
    tick();                       // edge k
    check("held busy k", busy, 1);
    check("held result k", result, 8'h02);
    for (int i = 1; i <= 17; i++) begin
      tick();
      check("held done", done, (i == 8 || i == 17) ? 1 : 0);
      check("held busy", busy, (i == 8 || i == 17) ? 0 : 1);
      check("held result", result, (i < 8) ? 8'h02 : 8'h30);
      if (i == 17) start = 1'b0;
    end
    tick();
    check("held end done", done, 0);
    check("held end busy", busy, 0);
    check("held end result", result, 8'h30);
    check("held end cout", cout, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_serial_add_ctrl
